// File: rtl/draw_arb_pkg.sv
// ============================================================================
// draw_arb_pkg : shared requester indices, field widths and FSM encoding
// Rev 1.0
// ============================================================================
`default_nettype none

package draw_arb_pkg;

    localparam int REQ_SCREEN     = 0;
    localparam int REQ_COIN_DRAW  = 1;
    localparam int REQ_CAR_DRAW   = 2;
    localparam int REQ_CAR_ERASE  = 3;
    localparam int REQ_COIN_ERASE = 4;

    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int COLOUR_W = 9;
    localparam int ADDR_W   = 15;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/arb_pick.sv
// ============================================================================
// arb_pick : one-hot winner selector, first asserted request from start index
// Rev 1.0
// ============================================================================
`default_nettype none

module arb_pick #(
    parameter int N_REQ = 5,
    parameter int IDX_W = 3
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] start,
    output logic [N_REQ-1:0] onehot,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    logic [IDX_W:0] cand;

    always_comb begin
        onehot = '0;
        idx    = '0;
        valid  = 1'b0;
        cand   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            // start + k never exceeds 2*N_REQ-2, so one subtraction wraps it
            cand = {1'b0, start} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(N_REQ)) begin
                cand = cand - (IDX_W+1)'(N_REQ);
            end
            if (!valid && req[cand[IDX_W-1:0]]) begin
                valid                    = 1'b1;
                idx                      = cand[IDX_W-1:0];
                onehot[cand[IDX_W-1:0]]  = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/draw_port_arbiter.sv
// ============================================================================
// draw_port_arbiter : request/grant sharing of the VGA pixel port and map ROM
// Optional macro DRAW_ARB_RR_EN selects round-robin instead of fixed priority.
// Rev 1.0
// ============================================================================
`default_nettype none

module draw_port_arbiter
    import draw_arb_pkg::*;
#(
    parameter int N_REQ          = 5,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ-1:0]        done,
    input  logic [X_W*N_REQ-1:0]    x_in,
    input  logic [Y_W*N_REQ-1:0]    y_in,
    input  logic [COLOUR_W*N_REQ-1:0] colour_in,
    input  logic [N_REQ-1:0]        plot_in,
    input  logic [ADDR_W*N_REQ-1:0] addr_in,
    output logic [N_REQ-1:0]        gnt,
    output logic [X_W-1:0]          oX,
    output logic [Y_W-1:0]          oY,
    output logic [COLOUR_W-1:0]     oColour,
    output logic                    oPlot,
    output logic [ADDR_W-1:0]       oAddress,
    output logic                    busy,
    output logic                    timeout
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    arb_state_t       state;
    logic [IDX_W-1:0] gidx;
    logic [WD_W-1:0]  wd_cnt;
    logic [IDX_W-1:0] start_idx;
    logic [N_REQ-1:0] pick_onehot;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_valid;
    logic             wd_expired;
    logic             release_now;

    arb_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req    (req),
        .start  (start_idx),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .valid  (pick_valid)
    );

`ifdef DRAW_ARB_RR_EN
    logic [IDX_W-1:0] rr_ptr;

    assign start_idx = (rr_ptr == IDX_W'(N_REQ - 1)) ? '0 : rr_ptr + 1'b1;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rr_ptr <= IDX_W'(N_REQ - 1);
        end else if (state == ST_IDLE && pick_valid) begin
            rr_ptr <= pick_idx;
        end
    end
`else
    assign start_idx = '0;
`endif

    assign wd_expired  = (wd_cnt == WD_LAST);
    assign release_now = done[gidx] || !req[gidx] || wd_expired;
    assign busy        = (state != ST_IDLE);

    // ROM address bypasses the register stage; the ROM supplies the latency
    always_comb begin
        oAddress = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                oAddress = oAddress | addr_in[i*ADDR_W +: ADDR_W];
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state   <= ST_IDLE;
            gnt     <= '0;
            gidx    <= '0;
            wd_cnt  <= '0;
            oX      <= '0;
            oY      <= '0;
            oColour <= '0;
            oPlot   <= 1'b0;
            timeout <= 1'b0;
        end else begin
            timeout <= 1'b0;
            oPlot   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        state  <= ST_GRANT;
                        gnt    <= pick_onehot;
                        gidx   <= pick_idx;
                        wd_cnt <= '0;
                    end
                end
                ST_GRANT: begin
                    oX      <= x_in[gidx*X_W +: X_W];
                    oY      <= y_in[gidx*Y_W +: Y_W];
                    oColour <= colour_in[gidx*COLOUR_W +: COLOUR_W];
                    if (release_now) begin
                        state   <= ST_RELEASE;
                        gnt     <= '0;
                        timeout <= wd_expired && !done[gidx];
                    end else begin
                        oPlot <= plot_in[gidx];
                        if (wd_cnt != '1) begin
                            wd_cnt <= wd_cnt + 1'b1;
                        end
                    end
                end
                ST_RELEASE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    gnt   <= '0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_draw_port_arbiter.sv
// ============================================================================
// tb_draw_port_arbiter : scoreboard-driven bench for draw_port_arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_draw_port_arbiter;
    import draw_arb_pkg::*;

    localparam int N = 5;

    logic              clock = 1'b0;
    logic              resetn = 1'b0;
    logic [N-1:0]      req = '0;
    logic [N-1:0]      done = '0;
    logic [8*N-1:0]    x_in = '0;
    logic [7*N-1:0]    y_in = '0;
    logic [9*N-1:0]    colour_in = '0;
    logic [N-1:0]      plot_in = '0;
    logic [15*N-1:0]   addr_in = '0;
    logic [N-1:0]      gnt;
    logic [7:0]        oX;
    logic [6:0]        oY;
    logic [8:0]        oColour;
    logic              oPlot;
    logic [14:0]       oAddress;
    logic              busy;
    logic              timeout;

    int n_vec = 0;
    int n_err = 0;

    logic [N-1:0] gq[$];
    logic [24:0]  pq[$];

    draw_port_arbiter #(
        .N_REQ          (N),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clock     (clock),
        .resetn    (resetn),
        .req       (req),
        .done      (done),
        .x_in      (x_in),
        .y_in      (y_in),
        .colour_in (colour_in),
        .plot_in   (plot_in),
        .addr_in   (addr_in),
        .gnt       (gnt),
        .oX        (oX),
        .oY        (oY),
        .oColour   (oColour),
        .oPlot     (oPlot),
        .oAddress  (oAddress),
        .busy      (busy),
        .timeout   (timeout)
    );

    always #5 clock = ~clock;

    task automatic set_pix(input int i, input logic [7:0] x, input logic [6:0] y,
                           input logic [8:0] c, input logic p);
        x_in[i*8 +: 8]      = x;
        y_in[i*7 +: 7]      = y;
        colour_in[i*9 +: 9] = c;
        plot_in[i]          = p;
    endtask

    task automatic apply_reset();
        req = '0; done = '0; plot_in = '0;
        resetn = 1'b0;
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
    endtask

    task automatic wait_gnt(output logic ok);
        ok = 1'b0;
        for (int k = 0; k < 10 && !ok; k++) begin
            @(negedge clock);
            if (gnt != '0) ok = 1'b1;
        end
        if (!ok) begin
            n_vec++; n_err++;
            $display("FAIL gnt_wait: gnt=%b required nonzero within 10 cycles", gnt);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        #3;
        n_vec++;
        if ({gnt, oX, oY, oColour, oPlot, busy, timeout, oAddress} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: gnt=%b oX=%0d oY=%0d oC=%h plot=%b busy=%b to=%b addr=%h required all 0",
                     gnt, oX, oY, oColour, oPlot, busy, timeout, oAddress);
        end
        apply_reset();
    endtask

    task automatic test_single();
        logic [N-1:0] eg;
        logic [24:0]  ep;
        logic         ok;
        set_pix(REQ_CAR_DRAW, 8'd40, 7'd30, 9'h1C0, 1'b1);
        addr_in[REQ_CAR_DRAW*15 +: 15] = 15'h1234;
        req = 5'b00100;
        gq.push_back(5'b00100);
        pq.push_back({1'b1, 9'h1C0, 7'd30, 8'd40});
        @(negedge clock);
        eg = gq.pop_front();
        n_vec++;
        if (gnt !== eg) begin n_err++; $display("FAIL single_gnt: gnt=%b required %b", gnt, eg); end
        n_vec++;
        if (oAddress !== 15'h1234) begin n_err++; $display("FAIL single_addr: addr=%h required 1234", oAddress); end
        @(negedge clock);
        ep = pq.pop_front();
        n_vec++;
        if ({oPlot, oColour, oY, oX} !== ep) begin
            n_err++;
            $display("FAIL single_pixel: plot=%b c=%h y=%0d x=%0d required %h", oPlot, oColour, oY, oX, ep);
        end
        done = 5'b00100;
        @(negedge clock);
        done = '0; req = '0;
        n_vec++;
        if ({gnt, oPlot, busy} !== {5'b0, 1'b0, 1'b1}) begin
            n_err++; $display("FAIL single_release: gnt=%b plot=%b busy=%b required 00000 0 1", gnt, oPlot, busy);
        end
        @(negedge clock);
        n_vec++;
        if ({busy, oAddress} !== 16'h0) begin
            n_err++; $display("FAIL single_idle: busy=%b addr=%h required 0 0000", busy, oAddress);
        end
        ok = 1'b1;
    endtask

    task automatic test_order();
        logic ok;
        logic [N-1:0] eg;
        int gap;
        apply_reset();
        // leave any round-robin pointer at index 0
        req = 5'b00001;
        wait_gnt(ok);
        done = 5'b00001;
        @(negedge clock);
        done = '0; req = '0;
        @(negedge clock);
        req = 5'b10011;
`ifdef DRAW_ARB_RR_EN
        gq.push_back(5'b00010); gq.push_back(5'b10000); gq.push_back(5'b00001);
`else
        gq.push_back(5'b00001); gq.push_back(5'b00010); gq.push_back(5'b10000);
`endif
        gap = 0;
        for (int n = 0; n < 3; n++) begin
            ok = 1'b0;
            for (int k = 0; k < 10 && !ok; k++) begin
                @(negedge clock);
                if (gnt != '0) ok = 1'b1; else gap++;
            end
            eg = gq.pop_front();
            n_vec++;
            if (gnt !== eg) begin n_err++; $display("FAIL order_%0d: gnt=%b required %b", n, gnt, eg); end
            if (n > 0) begin
                n_vec++;
                if (gap !== 2) begin n_err++; $display("FAIL order_gap_%0d: gap=%0d required 2", n, gap); end
            end
            done = eg;
            @(negedge clock);
            gap = (gnt == '0) ? 1 : 0;
            done = '0;
            req = req & ~eg;
        end
    endtask

    task automatic test_no_preempt();
        logic ok;
        int bad;
        req = 5'b01000;
        wait_gnt(ok);
        req[REQ_SCREEN] = 1'b1;
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            if (gnt !== 5'b01000) bad++;
        end
        n_vec++;
        if (bad != 0) begin n_err++; $display("FAIL nopreempt_hold: gnt=%b bad_cycles=%0d required 01000", gnt, bad); end
        done = 5'b01000;
        @(negedge clock);
        done = '0; req[REQ_CAR_ERASE] = 1'b0;
        @(negedge clock);
        n_vec++;
        if (gnt !== 5'b00000) begin n_err++; $display("FAIL nopreempt_gap: gnt=%b required 00000", gnt); end
        @(negedge clock);
        n_vec++;
        if (gnt !== 5'b00001) begin n_err++; $display("FAIL nopreempt_next: gnt=%b required 00001", gnt); end
        done = 5'b00001;
        @(negedge clock);
        done = '0; req = '0;
        @(negedge clock);
    endtask

    task automatic test_watchdog(input logic use_done);
        logic ok;
        int cnt;
        logic early;
        req = 5'b00010;
        wait_gnt(ok);
        cnt = 0; early = 1'b0;
        for (int k = 0; k < 40 && gnt != '0; k++) begin
            cnt++;
            if (timeout) early = 1'b1;
            if (use_done && cnt == 16) done = 5'b00010;
            @(negedge clock);
        end
        done = '0;
        n_vec++;
        if (cnt !== 16 || early) begin
            n_err++; $display("FAIL wd_len_%0d: grant_cycles=%0d early_to=%b required 16 0", use_done, cnt, early);
        end
        n_vec++;
        if (timeout !== !use_done) begin
            n_err++; $display("FAIL wd_pulse_%0d: timeout=%b required %b", use_done, timeout, !use_done);
        end
        req = '0;
        @(negedge clock);
        n_vec++;
        if (timeout !== 1'b0) begin n_err++; $display("FAIL wd_once_%0d: timeout=%b required 0", use_done, timeout); end
    endtask

    task automatic test_stray();
        logic ok;
        logic p;
        logic [14:0] a;
        logic [24:0] ep;
        int bad_p, bad_g, bad_a;
        set_pix(REQ_SCREEN, 8'd7, 7'd9, 9'h011, 1'b1);
        set_pix(REQ_COIN_ERASE, 8'd200, 7'd100, 9'h1FF, 1'b0);
        addr_in[0 +: 15] = 15'h0ABC;
        req = 5'b00001;
        wait_gnt(ok);
        n_vec++;
        if (oAddress !== 15'h0ABC) begin n_err++; $display("FAIL stray_addr0: addr=%h required 0abc", oAddress); end
        bad_p = 0; bad_g = 0; bad_a = 0;
        for (int k = 0; k < 6; k++) begin
            p = 1'($urandom_range(0, 1));
            plot_in[REQ_SCREEN] = p;
            plot_in[REQ_COIN_ERASE] = ~p;
            done = (k % 2 == 0) ? 5'b00100 : 5'b00000;
            pq.push_back({p, 9'h011, 7'd9, 8'd7});
            @(negedge clock);
            ep = pq.pop_front();
            if ({oPlot, oColour, oY, oX} !== ep) bad_p++;
            if (gnt !== 5'b00001) bad_g++;
            a = 15'($urandom);
            addr_in[0 +: 15] = a;
            #1;
            if (oAddress !== a) bad_a++;
        end
        n_vec++;
        if (bad_p != 0) begin n_err++; $display("FAIL stray_plot: bad_cycles=%0d required 0", bad_p); end
        n_vec++;
        if (bad_g != 0) begin n_err++; $display("FAIL stray_gnt: gnt=%b bad_cycles=%0d required 00001", gnt, bad_g); end
        n_vec++;
        if (bad_a != 0) begin n_err++; $display("FAIL stray_addr: bad_cycles=%0d required 0", bad_a); end
        done = 5'b00001;
        @(negedge clock);
        done = '0; req = '0;
        @(negedge clock);
        n_vec++;
        if (oAddress !== 15'h0) begin n_err++; $display("FAIL stray_addr_idle: addr=%h required 0000", oAddress); end
    endtask

    task automatic test_async_reset();
        logic ok;
        set_pix(REQ_CAR_DRAW, 8'd1, 7'd2, 9'h003, 1'b1);
        req = 5'b00100;
        wait_gnt(ok);
        @(negedge clock);
        n_vec++;
        if (oPlot !== 1'b1) begin n_err++; $display("FAIL arst_pre: plot=%b required 1", oPlot); end
        #2 resetn = 1'b0;
        #1;
        n_vec++;
        if ({gnt, oPlot, busy} !== 7'b0) begin
            n_err++; $display("FAIL arst_drop: gnt=%b plot=%b busy=%b required 00000 0 0", gnt, oPlot, busy);
        end
        #1 resetn = 1'b1;
        @(negedge clock);
        n_vec++;
        if (gnt !== 5'b00100) begin n_err++; $display("FAIL arst_regrant: gnt=%b required 00100", gnt); end
        done = 5'b00100;
        @(negedge clock);
        done = '0; req = '0;
        @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL sim_time_limit: run did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_order();
        test_no_preempt();
        test_watchdog(1'b0);
        @(negedge clock);
        test_watchdog(1'b1);
        @(negedge clock);
        test_stray();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/draw_port_arbiter.md
Name: draw_port_arbiter

Overview:
- Shares the single VGA pixel-write port and map-ROM address bus between the draw/erase engines: screen, coin draw, car draw, car erase and coin erase.
- Each engine raises a request, receives a one-hot grant, streams pixels, then signals done.
- Replaces the per-state combinational output mux with a request/grant handshake, a registered pixel path and a stall watchdog.
- Sits between the animation controller's engines and the VGA adapter / map ROMs.

Parameters:
- N_REQ, 5, number of requesters. Index 0 = screen, 1 = coin draw, 2 = car draw, 3 = car erase, 4 = coin erase.
- TIMEOUT_CYCLES, 20000, maximum cycles a grant may be held before forced release. Exceeds 160x120 = 19200.

Ports:
- clock  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- req  in  N_REQ  per-requester request level
- done  in  N_REQ  per-requester completion pulse
- x_in  in  8*N_REQ  packed pixel X, requester i at bits [8i+7:8i]
- y_in  in  7*N_REQ  packed pixel Y
- colour_in  in  9*N_REQ  packed pixel colour
- plot_in  in  N_REQ  per-requester plot strobe
- addr_in  in  15*N_REQ  packed map-ROM address
- gnt  out  N_REQ  one-hot grant, registered
- oX  out  8  muxed X, registered
- oY  out  7  muxed Y, registered
- oColour  out  9  muxed colour, registered
- oPlot  out  1  muxed plot, registered
- oAddress  out  15  muxed ROM address, combinational from gnt
- busy  out  1  high in GRANT or RELEASE
- timeout  out  1  one-cycle pulse on watchdog release

Behaviour:
- Reset (async, resetn=0): state=IDLE; gnt, oX, oY, oColour, oPlot, busy, timeout, watchdog counter all 0. The round-robin pointer (RR builds only) resets to N_REQ-1. Reset mid-grant drops the grant immediately.
- FSM states: IDLE, GRANT, RELEASE.
- IDLE → GRANT:
  - If any req bit is high, latch the winner; gnt goes one-hot on the next edge.
  - Winner is the lowest asserted index (fixed priority).
  - Grant latency is exactly 1 cycle from req seen high.
- GRANT, held until one of the following; each moves to RELEASE with gnt cleared on that edge:
  - done[g]=1 (normal completion).
  - req[g]=0 (abandon).
  - Watchdog reaches TIMEOUT_CYCLES-1; timeout pulses for 1 cycle.
  - If done[g] and the watchdog expire together, done wins and timeout stays 0.
- Ignored inputs: done and plot from non-granted requesters. A higher-priority req during GRANT does not preempt.
- RELEASE → IDLE: exactly one cycle, gnt=0, oPlot=0. Gives the finished requester a cycle to drop req. Back-to-back grants are therefore 2 cycles apart.
- Watchdog:
  - Clears on entry to GRANT and increments each GRANT cycle.
  - Width $clog2(TIMEOUT_CYCLES); saturates, never wraps.
- Pixel path:
  - oX/oY/oColour register the granted slice every cycle in GRANT.
  - oPlot = plot_in[g] registered.
  - Fixed 1-cycle latency input→output, so an engine's ROM-read pipeline is preserved.
  - Outside GRANT, oPlot=0 and oX/oY/oColour hold their last value.
- oAddress:
  - Combinational slice addr_in[g] while gnt≠0; otherwise 0.
  - Zero-latency because the ROM adds its own cycle.
- busy = (state≠IDLE).

Optional Feature:
- Macro DRAW_ARB_RR_EN.
- Defined: round-robin arbitration.
  - Pointer holds the last granted index.
  - In IDLE, search begins at pointer+1 modulo N_REQ.
  - Pointer updates on each grant.
- Undefined: fixed priority, index 0 highest, no pointer register.

Decomposition:
- Shared package draw_arb_pkg holds:
  - Requester index constants: REQ_SCREEN=0, REQ_COIN_DRAW=1, REQ_CAR_DRAW=2, REQ_CAR_ERASE=3, REQ_COIN_ERASE=4.
  - FSM state encoding.
  - Field widths: X=8, Y=7, COLOUR=9, ADDR=15.
- One sub-module: arb_pick, a combinational one-hot winner selector taking req and a start index. Fixed priority ties the start index to 0.

Test Plan:
- Single request: req=5'b00100, drive x_in[2]=8'd40, y_in[2]=7'd30, colour=9'h1C0, plot=1 → gnt=5'b00100 one cycle later; oX=40, oY=30, oColour=1C0, oPlot=1 one cycle after that. done[2] pulse → RELEASE, gnt=0, then IDLE.
- Simultaneous req=5'b10011, fixed priority → grant order 0, 1, 4; each grant separated by 2 idle cycles. With DRAW_ARB_RR_EN and pointer=0 → order 1, 4, 0.
- No preemption: grant 3 active, raise req[0] → gnt stays 5'b01000 until done[3]; req[0] granted 2 cycles later.
- Watchdog: TIMEOUT_CYCLES=16, req[1] held, no done → timeout=1 exactly at cycle 16 of GRANT; gnt=0. Same run with done[1] on cycle 16 → timeout=0.
- Stray inputs: grant 0, pulse done[2] and plot_in[4] → gnt unchanged, oPlot tracks plot_in[0] only. oAddress=addr_in[0] same cycle; 0 when idle.
- Async reset mid-GRANT: resetn low between clock edges → gnt, oPlot, busy read 0 before the next edge; after release, re-arbitration starts from IDLE.
